// File: rtl/jesd204_lane_release_ctrl.sv
// jesd204_lane_release_ctrl: waits for lane latencies, checks lane skew, then releases the elastic buffers.
module jesd204_lane_release_ctrl #(
  parameter int NUM_LANES       = 1,
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_LANES-1:0]    cfg_lanes_disable,
  input  logic [13:0]             cfg_max_skew,
  input  logic [7:0]              cfg_release_delay,
  input  logic [15:0]             cfg_timeout,
  input  logic [14*NUM_LANES-1:0] lane_latency,
  input  logic [NUM_LANES-1:0]    lane_latency_ready,
  output logic                    buffer_release,
  output logic [13:0]             min_latency,
  output logic [13:0]             max_latency,
  output logic [2:0]              status_state,
  output logic                    error_skew,
  output logic                    error_timeout,
  output logic                    error_lost
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_DELAY, S_REL, S_ERR} state_t;
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int NP = 2 ** LW;
  state_t            r_state, w_next;
  logic [NUM_LANES-1:0] r_dis;
  logic [13:0]       r_skew, r_run_min, r_run_max;
  logic [7:0]        r_delay, r_dcnt;
  logic [15:0]       r_timeout, r_tcnt, w_tinc;
  logic [LW-1:0]     r_idx;
  logic              r_any;
  logic [13:0]       w_lat [NP];
  logic [NP-1:0]     w_dis_p;
  logic [13:0]       w_lat_k, w_cmin, w_cmax, w_fmin, w_fmax;
  logic              w_en_k, w_cany, w_last, w_skew_bad, w_tout, w_ready, w_lost, w_live;
  // Pad the lane view to a power of two so the scan index never reaches outside it
  for (genvar i = 0; i < NP; i++) begin : g_lane
    if (i < NUM_LANES) begin : g_real
      assign w_lat[i]   = lane_latency[14*i +: 14];
      assign w_dis_p[i] = r_dis[i];
    end else begin : g_pad
      assign w_lat[i]   = '0;
      assign w_dis_p[i] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && !enable) w_next = S_IDLE;
    else if (w_live && w_lost)        w_next = S_ERR;
    else
      case (r_state)
        S_IDLE:  w_next = enable ? S_WAIT : S_IDLE;
        S_WAIT:  w_next = w_ready ? S_SCAN : w_tout ? S_ERR : S_WAIT;
        S_SCAN:  w_next = !w_last ? S_SCAN : w_skew_bad ? S_ERR : S_DELAY;
        S_DELAY: w_next = r_dcnt == r_delay ? S_REL : S_DELAY;
        default: w_next = r_state;
      endcase
  end
  always_comb begin
    w_en_k     = ~w_dis_p[r_idx];
    w_lat_k    = w_lat[r_idx];
    w_cmin     = w_en_k && w_lat_k < r_run_min ? w_lat_k : r_run_min;
    w_cmax     = w_en_k && w_lat_k > r_run_max ? w_lat_k : r_run_max;
    w_cany     = r_any | w_en_k;
    w_fmin     = w_cany ? w_cmin : 14'd0;
    w_fmax     = w_cany ? w_cmax : 14'd0;
    w_skew_bad = (w_fmax - w_fmin) > r_skew;
    w_last     = r_idx == LW'(NUM_LANES - 1);
    w_tinc     = &r_tcnt ? r_tcnt : r_tcnt + 16'd1;
    w_tout     = r_timeout != 16'd0 && w_tinc == r_timeout;
    w_ready    = &(lane_latency_ready | r_dis);
    w_lost     = |(~lane_latency_ready & ~r_dis);
    w_live     = r_state == S_SCAN || r_state == S_DELAY || r_state == S_REL;
    status_state = r_state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_dis <= '0; r_skew <= '0; r_delay <= '0; r_timeout <= '0;
      r_tcnt <= '0; r_idx <= '0; r_dcnt <= '0; r_any <= 1'b0;
      r_run_min <= '0; r_run_max <= '0;
      min_latency <= '0; max_latency <= '0; buffer_release <= 1'b0;
      error_skew <= 1'b0; error_timeout <= 1'b0; error_lost <= 1'b0;
    end else begin
      if (r_state == S_IDLE && enable) begin
        r_dis <= cfg_lanes_disable; r_skew <= cfg_max_skew;
        r_delay <= cfg_release_delay; r_timeout <= cfg_timeout;
        r_tcnt <= '0; r_idx <= '0;
        error_skew <= 1'b0; error_timeout <= 1'b0; error_lost <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        r_tcnt <= w_tinc;
        r_run_min <= 14'h3FFF; r_run_max <= '0; r_any <= 1'b0; r_idx <= '0;
      end
      if (r_state == S_SCAN) begin
        r_run_min <= w_cmin; r_run_max <= w_cmax; r_any <= w_cany; r_idx <= r_idx + 1'b1;
        if (w_last) begin
          min_latency <= w_fmin; max_latency <= w_fmax;
        end
      end
      r_dcnt <= r_state == S_DELAY ? r_dcnt + 8'd1 : 8'd0;
      buffer_release <= w_next == S_REL;
      if (w_next == S_ERR && r_state != S_ERR) begin
        error_lost    <= error_lost | (w_live && w_lost);
        error_skew    <= error_skew | (r_state == S_SCAN && !w_lost);
        error_timeout <= error_timeout | (r_state == S_WAIT);
      end
    end
endmodule

// File: tb/tb_jesd204_lane_release_ctrl.sv
// tb_jesd204_lane_release_ctrl: directed scenarios for the 4-lane release controller.
module tb_jesd204_lane_release_ctrl;
  logic        clk = 0, reset = 1, enable = 0;
  logic [3:0]  cfg_lanes_disable = 0, lane_latency_ready = 0;
  logic [13:0] cfg_max_skew = 0;
  logic [7:0]  cfg_release_delay = 0;
  logic [15:0] cfg_timeout = 0;
  logic [55:0] lane_latency = 0;
  logic        buffer_release, error_skew, error_timeout, error_lost;
  logic [13:0] min_latency, max_latency;
  logic [2:0]  status_state;
  int total = 0, bad = 0;

  jesd204_lane_release_ctrl #(.NUM_LANES(4), .DATA_PATH_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_lanes_disable(cfg_lanes_disable),
    .cfg_max_skew(cfg_max_skew), .cfg_release_delay(cfg_release_delay), .cfg_timeout(cfg_timeout),
    .lane_latency(lane_latency), .lane_latency_ready(lane_latency_ready),
    .buffer_release(buffer_release), .min_latency(min_latency), .max_latency(max_latency),
    .status_state(status_state), .error_skew(error_skew), .error_timeout(error_timeout),
    .error_lost(error_lost));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    total++; if ({status_state, buffer_release, min_latency, max_latency, error_skew, error_timeout, error_lost} !== 34'd0) begin bad++; $display("FAIL reset_async got=%h exp=0", {status_state, buffer_release, min_latency, max_latency}); end
    tick; tick; reset = 0; tick; tick;
    total++; if (status_state !== 3'd0) begin bad++; $display("FAIL reset_idle_hold got=%0d exp=0", status_state); end
  endtask

  task automatic test_release;
    int exp_st [10] = '{2, 2, 2, 2, 3, 3, 3, 3, 4, 4};
    lane_latency = {14'd101, 14'd102, 14'd104, 14'd100};
    cfg_max_skew = 8; cfg_release_delay = 3; cfg_timeout = 0; cfg_lanes_disable = 0;
    lane_latency_ready = 0; enable = 1; tick;
    total++; if (status_state !== 3'd1) begin bad++; $display("FAIL rel_wait got=%0d exp=1", status_state); end
    cfg_max_skew = 0; cfg_release_delay = 0;
    tick; tick; lane_latency_ready = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++; if (status_state !== 3'(exp_st[i])) begin bad++; $display("FAIL rel_state cyc%0d got=%0d exp=%0d", i + 1, status_state, exp_st[i]); end
      total++; if (buffer_release !== (i >= 8)) begin bad++; $display("FAIL rel_br cyc%0d got=%0d exp=%0d", i + 1, buffer_release, i >= 8); end
    end
    total++; if (min_latency !== 14'd100 || max_latency !== 14'd104) begin bad++; $display("FAIL rel_minmax got=%0d/%0d exp=100/104", min_latency, max_latency); end
    total++; if ({error_skew, error_timeout, error_lost} !== 3'b000) begin bad++; $display("FAIL rel_err got=%b exp=000", {error_skew, error_timeout, error_lost}); end
    enable = 0; tick;
    total++; if (status_state !== 3'd0 || buffer_release !== 1'b0) begin bad++; $display("FAIL rel_abort got=%0d/%0d exp=0/0", status_state, buffer_release); end
  endtask

  task automatic test_skew;
    cfg_max_skew = 3; cfg_release_delay = 3; enable = 1; tick; tick;
    total++; if (status_state !== 3'd2) begin bad++; $display("FAIL skew_scan got=%0d exp=2", status_state); end
    repeat (4) tick;
    total++; if (status_state !== 3'd5 || error_skew !== 1'b1) begin bad++; $display("FAIL skew_err got=%0d/%0d exp=5/1", status_state, error_skew); end
    repeat (3) tick;
    total++; if (status_state !== 3'd5 || buffer_release !== 1'b0 || {error_timeout, error_lost} !== 2'b00) begin bad++; $display("FAIL skew_hold got=%0d/%0d/%b exp=5/0/00", status_state, buffer_release, {error_timeout, error_lost}); end
    enable = 0; tick;
    total++; if (status_state !== 3'd0 || error_skew !== 1'b1) begin bad++; $display("FAIL skew_persist got=%0d/%0d exp=0/1", status_state, error_skew); end
  endtask

  task automatic test_timeout;
    cfg_max_skew = 8; cfg_timeout = 50; lane_latency_ready = 4'b1011; enable = 1; tick;
    total++; if (status_state !== 3'd1 || error_skew !== 1'b0) begin bad++; $display("FAIL to_entry got=%0d/%0d exp=1/0", status_state, error_skew); end
    for (int i = 1; i < 50; i++) begin
      tick;
      total++; if (status_state !== 3'd1) begin bad++; $display("FAIL to_wait cyc%0d got=%0d exp=1", i + 1, status_state); end
    end
    tick;
    total++; if (status_state !== 3'd5 || error_timeout !== 1'b1 || error_skew !== 1'b0) begin bad++; $display("FAIL to_err got=%0d/%0d/%0d exp=5/1/0", status_state, error_timeout, error_skew); end
    enable = 0; tick;
  endtask

  task automatic test_disable;
    cfg_lanes_disable = 4'b0100; cfg_release_delay = 0;
    lane_latency = {14'd101, 14'd10, 14'd104, 14'd100};
    enable = 1; tick;
    total++; if (status_state !== 3'd1 || error_timeout !== 1'b0) begin bad++; $display("FAIL dis_entry got=%0d/%0d exp=1/0", status_state, error_timeout); end
    repeat (5) tick;
    total++; if (status_state !== 3'd3 || min_latency !== 14'd100 || max_latency !== 14'd104) begin bad++; $display("FAIL dis_minmax got=%0d %0d/%0d exp=3 100/104", status_state, min_latency, max_latency); end
    tick;
    total++; if (status_state !== 3'd4 || buffer_release !== 1'b1) begin bad++; $display("FAIL dis_rel got=%0d/%0d exp=4/1", status_state, buffer_release); end
  endtask

  task automatic test_lost;
    lane_latency_ready = 4'b1001; tick;
    total++; if (status_state !== 3'd5 || error_lost !== 1'b1 || buffer_release !== 1'b0 || {error_skew, error_timeout} !== 2'b00) begin bad++; $display("FAIL lost_err got=%0d/%0d/%0d exp=5/1/0", status_state, error_lost, buffer_release); end
    enable = 0; tick;
    total++; if (status_state !== 3'd0 || error_lost !== 1'b1) begin bad++; $display("FAIL lost_idle got=%0d/%0d exp=0/1", status_state, error_lost); end
    enable = 1; tick;
    total++; if (status_state !== 3'd1 || error_lost !== 1'b0) begin bad++; $display("FAIL lost_clear got=%0d/%0d exp=1/0", status_state, error_lost); end
    enable = 0; tick;
  endtask

  task automatic test_all_disabled;
    int exp_st [8] = '{1, 2, 2, 2, 2, 3, 3, 4};
    cfg_lanes_disable = 4'hF; lane_latency_ready = 0; cfg_release_delay = 1; cfg_max_skew = 0; cfg_timeout = 0;
    enable = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      total++; if (status_state !== 3'(exp_st[i])) begin bad++; $display("FAIL alldis_state cyc%0d got=%0d exp=%0d", i, status_state, exp_st[i]); end
    end
    total++; if (min_latency !== 14'd0 || max_latency !== 14'd0 || buffer_release !== 1'b1) begin bad++; $display("FAIL alldis_out got=%0d/%0d/%0d exp=0/0/1", min_latency, max_latency, buffer_release); end
    enable = 0; tick;
  endtask

  task automatic test_tie;
    cfg_lanes_disable = 0; lane_latency_ready = 0; cfg_timeout = 5; cfg_max_skew = 8;
    lane_latency = {14'd101, 14'd102, 14'd104, 14'd100};
    enable = 1; tick;
    repeat (4) tick;
    total++; if (status_state !== 3'd1) begin bad++; $display("FAIL tie_wait got=%0d exp=1", status_state); end
    lane_latency_ready = 4'hF; tick;
    total++; if (status_state !== 3'd2 || error_timeout !== 1'b0) begin bad++; $display("FAIL tie_scan got=%0d/%0d exp=2/0", status_state, error_timeout); end
    enable = 0; tick;
  endtask

  task automatic test_async_reset;
    cfg_timeout = 0; cfg_release_delay = 20; enable = 1; tick;
    repeat (7) tick;
    total++; if (status_state !== 3'd3 || max_latency !== 14'd104) begin bad++; $display("FAIL ar_delay got=%0d/%0d exp=3/104", status_state, max_latency); end
    #2 reset = 1; #1;
    total++; if ({status_state, buffer_release, min_latency, max_latency, error_skew, error_timeout, error_lost} !== 34'd0) begin bad++; $display("FAIL ar_zero got=%0d %0d/%0d exp=0 0/0", status_state, min_latency, max_latency); end
    enable = 0; tick; reset = 0; tick;
  endtask

  initial begin
    test_reset;
    test_release;
    test_skew;
    test_timeout;
    test_disable;
    test_lost;
    test_all_disabled;
    test_tie;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jesd204_lane_release_ctrl.md
JESD204_LANE_RELEASE_CTRL -- requirements
Module: jesd204_lane_release_ctrl

Interface
REQ-001 Parameters: NUM_LANES, default 1, lane count (1..32); DATA_PATH_WIDTH, default 4, octets per beat (4 or 8).
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  level; high starts/holds a release sequence, low aborts it.
REQ-005 cfg_lanes_disable  input  NUM_LANES  1 = lane excluded from wait and skew checks.
REQ-006 cfg_max_skew  input  14  maximum allowed max-min latency, in octets.
REQ-007 cfg_release_delay  input  8  extra cycles between a passed skew check and release.
REQ-008 cfg_timeout  input  16  WAIT timeout in cycles; 0 = no timeout.
REQ-009 lane_latency  input  14*NUM_LANES  per-lane latency in octets; lane i at bits [14i+13:14i].
REQ-010 lane_latency_ready  input  NUM_LANES  per-lane latency-valid flags.
REQ-011 buffer_release  output  1  elastic-buffer release to the lane buffers.
REQ-012 min_latency, max_latency  output  14 each  result of the last completed scan.
REQ-013 status_state  output  3  current state code.
REQ-014 error_skew, error_timeout, error_lost  output  1 each  error cause flags.

Function
REQ-015 States and codes: IDLE=0, WAIT=1, SCAN=2, DELAY=3, RELEASED=4, ERROR=5; status_state equals the registered state.
REQ-016 IDLE to WAIT: on the first cycle enable=1; all cfg_* inputs are captured on that edge; later cfg changes are ignored until the next IDLE.
REQ-017 enable=0 in any non-IDLE state: next state IDLE; buffer_release deasserts on the same edge.
REQ-018 IDLE to WAIT also clears the error flags, the timeout counter and the scan index.
REQ-019 WAIT to SCAN: when (lane_latency_ready | disable_captured) is all ones.
REQ-020 WAIT timeout: a 16-bit counter increments once per WAIT cycle and saturates at all ones; when it equals a nonzero cfg_timeout, next state ERROR and error_timeout=1.
REQ-021 If the all-ready condition and the timeout occur in the same cycle, the all-ready condition wins (SCAN).
REQ-022 SCAN duration: exactly NUM_LANES cycles; SCAN cycle k evaluates lane k.
REQ-023 SCAN running values: start at min=14'h3FFF and max=0; an enabled lane updates min/max with unsigned compares; a disabled lane leaves them unchanged.
REQ-024 End of SCAN: min_latency/max_latency are registered on the edge leaving SCAN.
REQ-025 End of SCAN with all lanes disabled: outputs min_latency=max_latency=0; the skew check passes.
REQ-026 Skew check: if (max-min) > cfg_max_skew as a 14-bit unsigned compare, next state ERROR and error_skew=1; otherwise next state DELAY.
REQ-027 DELAY duration: exactly cfg_release_delay+1 cycles, then RELEASED.
REQ-028 RELEASED: buffer_release=1 (registered) for as long as the state is held.
REQ-029 Lost lane: in SCAN, DELAY or RELEASED, an enabled lane's ready going 0 gives next state ERROR with error_lost=1; buffer_release drops on that edge.
REQ-030 ERROR: held until enable=0; buffer_release=0; only the triggering flag is set.
REQ-031 Error flags persist through ERROR and IDLE and are cleared only per REQ-018.
REQ-032 When several conditions coincide, priority is enable=0, then lost lane, then the state-specific transition.

Reset
REQ-033 Asynchronous reset forces: state IDLE, buffer_release=0, min_latency=0, max_latency=0, all error flags=0, all counters=0, status_state=0.
REQ-034 After reset release, the first transition happens no earlier than the first rising clk with enable=1.

Verification
REQ-035 NUM_LANES=4, latencies 100/104/102/101, all ready at once, cfg_max_skew=8, cfg_release_delay=3 -> SCAN 4 cycles, min=100, max=104, DELAY 4 cycles, buffer_release=1 on the 9th cycle after WAIT exits.
REQ-036 Same setup with cfg_max_skew=3 -> state ERROR, error_skew=1, buffer_release stays 0.
REQ-037 Lane 2 never ready, cfg_timeout=50 -> ERROR after exactly 50 WAIT cycles with error_timeout=1; a rerun with cfg_lanes_disable=4'b0100 -> release occurs and lane 2 is excluded from min/max.
REQ-038 In RELEASED, lane 1 ready dropped -> next cycle ERROR, error_lost=1, buffer_release=0; enable 0 then 1 -> flags cleared, state WAIT.
REQ-039 Reset asserted mid-DELAY, asynchronous to clk -> all outputs go to reset values immediately, without a clock edge.
REQ-040 All lanes disabled -> SCAN, min=max=0, DELAY, RELEASED; and all-ready coinciding with the timeout cycle -> SCAN, not ERROR.
